// File: rtl/wb_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | wb_pkg : shared types and constants for the writeback arbiter    |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
package wb_pkg;

   localparam int WB_DATA_W = 32;
   localparam int PREG_W    = 7;
   localparam int WB_ROB_W  = 3;

   typedef struct packed {
      logic [WB_DATA_W-1:0] data;
      logic [PREG_W-1:0]    rd;
      logic [WB_ROB_W-1:0]  rob_idx;
   } wb_entry_t;

   // True when a result tagged rob_idx is being squashed this cycle.
   function automatic logic is_killed(
      input logic                     mispredict,
      input logic [2**WB_ROB_W-1:0]   flush_mask,
      input logic [WB_ROB_W-1:0]      rob_idx
   );
      return mispredict && flush_mask[rob_idx];
   endfunction

endpackage
`default_nettype wire

// File: rtl/wb_fu_buffer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | wb_fu_buffer : compacted per-FU result buffer, slot 0 is oldest  |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module wb_fu_buffer
   import wb_pkg::*;
#(
   parameter int BUF_DEPTH = 2
)
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push_valid,
   input  wb_entry_t              push_entry,
   output logic                   push_ready,
   input  logic                   pop,
   input  logic                   mispredict,
   input  logic [2**WB_ROB_W-1:0] flush_mask,
   output logic                   head_valid,
   output wb_entry_t              head
);

   localparam int             IDX_W   = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam logic [IDX_W:0] CNT_ONE = (IDX_W+1)'(1);
   localparam logic [IDX_W:0] CNT_MAX = (IDX_W+1)'(BUF_DEPTH);

   wb_entry_t              slot_q [BUF_DEPTH];
   wb_entry_t              slot_d [BUF_DEPTH];
   logic [BUF_DEPTH-1:0]   vld_q;
   logic [BUF_DEPTH-1:0]   vld_d;
   logic [BUF_DEPTH-1:0]   keep;
   logic [IDX_W:0]         fill;
   logic                   push_en;

   // Slots stay compacted, so the top slot being valid means full.
   assign push_ready = !vld_q[BUF_DEPTH-1];
   assign head_valid = vld_q[0];
   assign head       = slot_q[0];
   assign push_en    = push_valid && push_ready &&
                       !is_killed(mispredict, flush_mask, push_entry.rob_idx);

   always_comb begin
      keep = '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
         keep[i] = vld_q[i]
                && !is_killed(mispredict, flush_mask, slot_q[i].rob_idx)
                && !((i == 0) && pop);
      end
   end

   // Kill, then pop, then compact survivors downward, then push.
   always_comb begin
      slot_d = slot_q;
      vld_d  = '0;
      fill   = '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
         if (keep[i]) begin
            slot_d[fill[IDX_W-1:0]] = slot_q[i];
            vld_d[fill[IDX_W-1:0]]  = 1'b1;
            fill                    = fill + CNT_ONE;
         end
      end
      if (push_en && (fill < CNT_MAX)) begin
         slot_d[fill[IDX_W-1:0]] = push_entry;
         vld_d[fill[IDX_W-1:0]]  = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q <= '0;
         for (int i = 0; i < BUF_DEPTH; i++) begin
            slot_q[i] <= '0;
         end
      end else begin
         vld_q  <= vld_d;
         slot_q <= slot_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | wb_arbiter : round-robin writeback arbiter over per-FU buffers   |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module wb_arbiter
   import wb_pkg::*;
#(
   parameter int NUM_FU    = 8,
   parameter int BUF_DEPTH = 2,
   parameter int ROB_W     = WB_ROB_W
)
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_FU-1:0]       fu_valid,
   output logic [NUM_FU-1:0]       fu_ready,
   input  logic [NUM_FU*32-1:0]    fu_data,
   input  logic [NUM_FU*7-1:0]     fu_rd,
   input  logic [NUM_FU*ROB_W-1:0] fu_rob_idx,
   output logic                    WB_valid,
   output logic [31:0]             WB_data,
   output logic [6:0]              WB_rd,
   output logic [ROB_W-1:0]        WB_rob_idx,
   input  logic                    mispredict,
   input  logic [2**ROB_W-1:0]     flush_mask
);

   localparam int              FU_W    = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
   localparam logic [FU_W-1:0] LAST_FU = FU_W'(NUM_FU - 1);

   wb_entry_t         push_entry [NUM_FU];
   wb_entry_t         head       [NUM_FU];
   logic [NUM_FU-1:0] head_valid;
   logic [NUM_FU-1:0] request;
   logic [NUM_FU-1:0] pop;

   logic [FU_W-1:0]   rr_ptr;
   logic [FU_W-1:0]   win;
   logic [FU_W-1:0]   cand;
   logic [FU_W-1:0]   rr_next;
   logic              grant;

   for (genvar k = 0; k < NUM_FU; k++) begin : g_fu
      assign push_entry[k].data    = fu_data[32*k +: 32];
      assign push_entry[k].rd      = fu_rd[7*k +: 7];
      assign push_entry[k].rob_idx = fu_rob_idx[ROB_W*k +: ROB_W];

      // A head being flushed this cycle must not win the bus.
      assign request[k] = head_valid[k] &&
                          !is_killed(mispredict, flush_mask, head[k].rob_idx);
      assign pop[k]     = grant && (win == FU_W'(k));

      wb_fu_buffer #(
         .BUF_DEPTH (BUF_DEPTH)
      ) u_buf (
         .clk        (clk),
         .rst        (rst),
         .push_valid (fu_valid[k]),
         .push_entry (push_entry[k]),
         .push_ready (fu_ready[k]),
         .pop        (pop[k]),
         .mispredict (mispredict),
         .flush_mask (flush_mask),
         .head_valid (head_valid[k]),
         .head       (head[k])
      );
   end

   // First requester at or after rr_ptr, wrapping modulo NUM_FU.
   always_comb begin
      grant = 1'b0;
      win   = '0;
      cand  = '0;
      for (int off = 0; off < NUM_FU; off++) begin
         cand = FU_W'((int'(rr_ptr) + off) % NUM_FU);
         if (!grant && request[cand]) begin
            grant = 1'b1;
            win   = cand;
         end
      end
   end

   assign rr_next = (win == LAST_FU) ? '0 : (win + FU_W'(1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr     <= '0;
         WB_valid   <= 1'b0;
         WB_data    <= '0;
         WB_rd      <= '0;
         WB_rob_idx <= '0;
      end else begin
         WB_valid <= grant;
         if (grant) begin
            rr_ptr     <= rr_next;
            WB_data    <= head[win].data;
            WB_rd      <= head[win].rd;
            WB_rob_idx <= head[win].rob_idx;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// Bench for wb_arbiter: queue-based reference model plus directed and random stimulus.
module tb_wb_arbiter;

   localparam int NUM_FU    = 8;
   localparam int BUF_DEPTH = 2;
   localparam int ROB_W     = 3;

   typedef struct packed {
      logic [31:0] d;
      logic [6:0]  rd;
      logic [2:0]  rob;
   } ent_t;

   logic                    clk = 1'b0;
   logic                    rst;
   logic [NUM_FU-1:0]       fu_valid;
   logic [NUM_FU-1:0]       fu_ready;
   logic [NUM_FU*32-1:0]    fu_data;
   logic [NUM_FU*7-1:0]     fu_rd;
   logic [NUM_FU*ROB_W-1:0] fu_rob_idx;
   logic                    WB_valid;
   logic [31:0]             WB_data;
   logic [6:0]              WB_rd;
   logic [ROB_W-1:0]        WB_rob_idx;
   logic                    mispredict;
   logic [2**ROB_W-1:0]     flush_mask;

   wb_arbiter #(
      .NUM_FU    (NUM_FU),
      .BUF_DEPTH (BUF_DEPTH),
      .ROB_W     (ROB_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .fu_valid   (fu_valid),
      .fu_ready   (fu_ready),
      .fu_data    (fu_data),
      .fu_rd      (fu_rd),
      .fu_rob_idx (fu_rob_idx),
      .WB_valid   (WB_valid),
      .WB_data    (WB_data),
      .WB_rd      (WB_rd),
      .WB_rob_idx (WB_rob_idx),
      .mispredict (mispredict),
      .flush_mask (flush_mask)
   );

   always #5 clk = ~clk;

   // Reference model state: per-FU FIFO queues, rr pointer, expected bus.
   ent_t q [NUM_FU][$];
   int   rr;
   logic e_valid;
   ent_t e_out;

   // Source side: one pending result per FU, held until accepted.
   logic pend_v [NUM_FU];
   ent_t pend   [NUM_FU];
   int   mode   [NUM_FU];   // 0 idle, 1 stream with rob=k, 2 random
   int   seq;

   int n_cmp;
   int n_fail;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [NUM_FU-1:0] exp_ready();
      logic [NUM_FU-1:0] r;
      for (int k = 0; k < NUM_FU; k++) r[k] = (q[k].size() < BUF_DEPTH);
      return r;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < NUM_FU; k++) q[k].delete();
      rr      = 0;
      e_valid = 1'b0;
      e_out   = '0;
   endtask

   task automatic sources_idle();
      for (int k = 0; k < NUM_FU; k++) begin
         pend_v[k] = 1'b0;
         pend[k]   = '0;
         mode[k]   = 0;
      end
   endtask

   task automatic refresh();
      for (int k = 0; k < NUM_FU; k++) begin
         if (!pend_v[k]) begin
            if (mode[k] == 1) begin
               pend_v[k]   = 1'b1;
               pend[k].d   = {8'(k), 24'(seq)};
               pend[k].rd  = 7'($urandom);
               pend[k].rob = 3'(k);
               seq++;
            end else if (mode[k] == 2 && $urandom_range(0, 3) != 0) begin
               pend_v[k]   = 1'b1;
               pend[k].d   = $urandom;
               pend[k].rd  = 7'($urandom);
               pend[k].rob = 3'($urandom);
            end
         end
      end
   endtask

   // One clock of the specification's rules, on the inputs about to be sampled.
   task automatic model_step(input logic mp, input logic [7:0] mask);
      logic rdy [NUM_FU];
      logic req [NUM_FU];
      int   w;
      for (int k = 0; k < NUM_FU; k++) begin
         rdy[k] = (q[k].size() < BUF_DEPTH);
         req[k] = (q[k].size() > 0) && !(mp && mask[q[k][0].rob]);
      end
      w = -1;
      for (int off = 0; off < NUM_FU; off++) begin
         int c;
         c = (rr + off) % NUM_FU;
         if (w < 0 && req[c]) w = c;
      end
      if (w >= 0) begin
         e_valid = 1'b1;
         e_out   = q[w][0];
         void'(q[w].pop_front());
         rr = (w + 1) % NUM_FU;
      end else begin
         e_valid = 1'b0;
      end
      if (mp) begin
         for (int k = 0; k < NUM_FU; k++)
            for (int i = q[k].size() - 1; i >= 0; i--)
               if (mask[q[k][i].rob]) q[k].delete(i);
      end
      for (int k = 0; k < NUM_FU; k++) begin
         if (pend_v[k] && rdy[k]) begin
            if (!(mp && mask[pend[k].rob])) q[k].push_back(pend[k]);
            pend_v[k] = 1'b0;
         end
      end
   endtask

   task automatic tick(input logic mp, input logic [7:0] mask);
      @(negedge clk);
      for (int k = 0; k < NUM_FU; k++) begin
         fu_valid[k]               = pend_v[k];
         fu_data[32*k +: 32]       = pend[k].d;
         fu_rd[7*k +: 7]           = pend[k].rd;
         fu_rob_idx[ROB_W*k +: ROB_W] = pend[k].rob;
      end
      mispredict = mp;
      flush_mask = mask;
      if (rst) begin
         model_reset();
      end else begin
         model_step(mp, mask);
         refresh();
      end
   endtask

   // Asynchronous reset asserted between edges, released at a negedge.
   task automatic do_reset();
      tick(1'b0, 8'h00);
      #2;
      rst = 1'b1;
      sources_idle();
      model_reset();
      tick(1'b0, 8'h00);
      tick(1'b0, 8'h00);
      rst = 1'b0;
   endtask

   always @(posedge clk) begin
      #1;
      chk("wb_valid",   32'(WB_valid),   32'(e_valid));
      chk("wb_data",    WB_data,         e_out.d);
      chk("wb_rd",      32'(WB_rd),      32'(e_out.rd));
      chk("wb_rob_idx", 32'(WB_rob_idx), 32'(e_out.rob));
      chk("fu_ready",   32'(fu_ready),   32'(exp_ready()));
   end

   initial begin
      int fair_seq [3];
      fair_seq = '{0, 1, 7};
      n_cmp = 0;
      n_fail = 0;
      seq = 0;
      rst = 1'b1;
      fu_valid = '0;
      fu_data = '0;
      fu_rd = '0;
      fu_rob_idx = '0;
      mispredict = 1'b0;
      flush_mask = '0;
      sources_idle();
      model_reset();

      tick(1'b0, 8'h00);
      tick(1'b0, 8'h00);
      chk("reset_wb_valid", 32'(WB_valid), 32'd0);
      chk("reset_fu_ready", 32'(fu_ready), 32'hFF);
      rst = 1'b0;

      // Single push from FU2, uncontended.
      pend_v[2] = 1'b1;
      pend[2]   = '{d: 32'h1234, rd: 7'd5, rob: 3'd3};
      tick(1'b0, 8'h00);
      tick(1'b0, 8'h00);
      chk("t1_not_yet", 32'(WB_valid), 32'd0);
      tick(1'b0, 8'h00);
      chk("t1_valid", 32'(WB_valid),   32'd1);
      chk("t1_data",  WB_data,         32'h1234);
      chk("t1_rd",    32'(WB_rd),      32'd5);
      chk("t1_rob",   32'(WB_rob_idx), 32'd3);
      tick(1'b0, 8'h00);
      chk("t1_gone", 32'(WB_valid), 32'd0);

      // Fairness across FU0, FU1, FU7.
      do_reset();
      mode[0] = 1;
      mode[1] = 1;
      mode[7] = 1;
      refresh();
      tick(1'b0, 8'h00);
      tick(1'b0, 8'h00);
      for (int i = 0; i < 6; i++) begin
         tick(1'b0, 8'h00);
         chk("fair_valid", 32'(WB_valid),   32'd1);
         chk("fair_order", 32'(WB_rob_idx), 32'(fair_seq[i % 3]));
      end

      // Backpressure on FU3 while FU0 streams.
      do_reset();
      mode[0] = 1;
      refresh();
      pend_v[3] = 1'b1;
      pend[3]   = '{d: 32'h3001, rd: 7'd31, rob: 3'd5};
      tick(1'b0, 8'h00);
      pend_v[3] = 1'b1;
      pend[3]   = '{d: 32'h3002, rd: 7'd32, rob: 3'd6};
      tick(1'b0, 8'h00);
      pend_v[3] = 1'b1;
      pend[3]   = '{d: 32'h3003, rd: 7'd33, rob: 3'd7};
      tick(1'b0, 8'h00);
      chk("t3_full", 32'(fu_ready[3]), 32'd0);
      chk("t3_held", 32'(pend_v[3]),   32'd1);
      tick(1'b0, 8'h00);
      chk("t3_freed", 32'(fu_ready[3]), 32'd1);
      mode[0] = 0;
      repeat (8) tick(1'b0, 8'h00);

      // Flush inside the buffer: rob 2 killed, rob 1 survives.
      do_reset();
      mode[0] = 1;
      refresh();
      pend_v[4] = 1'b1;
      pend[4]   = '{d: 32'h0A1, rd: 7'd11, rob: 3'd1};
      tick(1'b0, 8'h00);
      pend_v[4] = 1'b1;
      pend[4]   = '{d: 32'h0A2, rd: 7'd12, rob: 3'd2};
      tick(1'b0, 8'h00);
      tick(1'b1, 8'b0000_0100);
      mode[0] = 0;
      tick(1'b0, 8'h00);
      chk("t4_valid", 32'(WB_valid),   32'd1);
      chk("t4_rob",   32'(WB_rob_idx), 32'd1);
      chk("t4_data",  WB_data,         32'h0A1);
      for (int i = 0; i < 6; i++) begin
         tick(1'b0, 8'h00);
         chk("t4_no_rob2", 32'(WB_valid && (WB_rob_idx == 3'd2)), 32'd0);
      end

      // Flush at the input.
      do_reset();
      pend_v[5] = 1'b1;
      pend[5]   = '{d: 32'h66, rd: 7'd6, rob: 3'd6};
      tick(1'b1, 8'h40);
      tick(1'b0, 8'h00);
      chk("t5_ready", 32'(fu_ready[5]), 32'd1);
      chk("t5_none0", 32'(WB_valid),    32'd0);
      tick(1'b0, 8'h00);
      chk("t5_none1", 32'(WB_valid),    32'd0);

      // Async reset mid-stream with full buffers.
      do_reset();
      for (int k = 0; k < NUM_FU; k++) mode[k] = 1;
      refresh();
      repeat (6) tick(1'b0, 8'h00);
      chk("t6_pre_valid", 32'(WB_valid), 32'd1);
      tick(1'b0, 8'h00);
      #2;
      rst = 1'b1;
      sources_idle();
      model_reset();
      #1;
      chk("t6_async_valid", 32'(WB_valid), 32'd0);
      chk("t6_async_ready", 32'(fu_ready), 32'hFF);
      tick(1'b0, 8'h00);
      tick(1'b0, 8'h00);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick(1'b0, 8'h00);
         chk("t6_quiet", 32'(WB_valid), 32'd0);
      end

      // Randomized traffic with random flushes.
      for (int phase = 0; phase < 2; phase++) begin
         do_reset();
         for (int k = 0; k < NUM_FU; k++) mode[k] = 2;
         refresh();
         for (int i = 0; i < 1500; i++) begin
            logic       mp;
            logic [7:0] mask;
            mp   = ($urandom_range(0, 7) == 0);
            mask = 8'($urandom);
            tick(mp, mask);
         end
         for (int k = 0; k < NUM_FU; k++) mode[k] = 0;
         repeat (20) tick(1'b0, 8'h00);
      end

      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
Writeback/completion arbiter. It sits at the output end of the execute units and is the producer of the WB_valid/WB_data/WB_rd bus that the issue stage consumes for register-file write, wakeup and forwarding. Each functional unit (FU) pushes results into a small per-FU buffer through a valid/ready handshake. The arbiter picks one result per cycle, round-robin, and drives the writeback bus from a register. Mispredict flushes are honoured by ROB index both in the buffers and at the inputs.

Parameters:
NUM_FU, 8, number of FUs; matches the 8-bit EX_ready vector and 3-bit fu_sel.
BUF_DEPTH, 2, entries per FU buffer; legal values 1..4.
ROB_W, 3, ROB index width; flush_mask is 2**ROB_W bits.

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
fu_valid  in  NUM_FU  per-FU result valid
fu_ready  out  NUM_FU  per-FU buffer can accept
fu_data  in  NUM_FU*32  result data, FU k at bits [32k+31:32k]
fu_rd  in  NUM_FU*7  physical destination register; 0 means no register write
fu_rob_idx  in  NUM_FU*ROB_W  ROB index of the result
WB_valid  out  1  writeback bus valid
WB_data  out  32  writeback data
WB_rd  out  7  writeback physical register
WB_rob_idx  out  ROB_W  ROB index, used for completion marking
mispredict  in  1  flush request
flush_mask  in  2**ROB_W  ROB slots to kill

Behaviour:
- Reset (asynchronous, active-high), values forced immediately:
  - WB_valid=0, WB_data=0, WB_rd=0, WB_rob_idx=0.
  - All buffer entries invalid.
  - Round-robin pointer rr_ptr=0.
  - fu_ready = all ones (after reset settles).
  - Reset asserted mid-operation discards all buffered and presented results. No partial state survives.
- Per-FU buffer:
  - BUF_DEPTH slots, kept compacted; slot 0 is oldest.
  - fu_ready[k] = (valid-slot count < BUF_DEPTH). It is computed from registered state only: no same-cycle pass-through from pop, no combinational path from fu_valid.
  - Push on fu_valid[k] && fu_ready[k]; the entry goes to the lowest free slot after this cycle's pop/kill compaction.
  - An input whose flush_mask[fu_rob_idx] is set while mispredict=1 is dropped: it is accepted (ready honoured) but not stored.
- Flush:
  - When mispredict=1, every stored entry with flush_mask[rob_idx]=1 is invalidated at the clock edge.
  - Remaining entries shift down, preserving order.
  - Flushed entries do not request arbitration in the flush cycle.
- Arbitration:
  - request[k] = slot0 valid for FU k && !(mispredict && flush_mask[slot0.rob_idx]).
  - The winner is the first requesting k searching from rr_ptr upward, with wrap-around modulo NUM_FU.
  - On a grant to winner w: rr_ptr <= (w+1) mod NUM_FU, and FU w's slot 0 is popped at the same edge.
  - No request: rr_ptr holds.
- Output register:
  - On a grant: WB_valid<=1, and WB_data/WB_rd/WB_rob_idx are loaded from the winner.
  - Otherwise: WB_valid<=0; data fields hold their previous value.
  - The WB bus has no backpressure; consumers must accept every cycle.
  - A presented WB beat is never retracted, even if a flush hitting its rob_idx arrives in that cycle. The ROB and issue stage handle a completed-then-flushed entry.
- Latency:
  - A result pushed at edge t into an empty buffer, uncontended, appears on WB_valid after edge t+1.
  - Throughput: one result per cycle total.
- rd=0 results still use a WB slot for ROB completion; register-file consumers ignore rd=0.
- Simultaneous push and pop on a full buffer: pop frees the slot, but fu_ready was 0 that cycle, so no push occurs.
- Simultaneous push, pop and flush on the same FU: evaluation order is kill, then pop, then compact, then push.

Decomposition:
- Package wb_pkg:
  - typedef wb_entry_t: packed {data[31:0], rd[6:0], rob_idx[ROB_W-1:0]}.
  - constants WB_DATA_W=32, PREG_W=7.
- Sub-module wb_fu_buffer: one compacted BUF_DEPTH buffer with push/pop/flush and head output, instantiated NUM_FU times.
- Top level holds the round-robin arbiter and the output register.

Test Plan:
- Reset then single push: FU2 sends data=0x1234, rd=5, rob=3 → one cycle later WB_valid=1, WB_data=0x1234, WB_rd=5, WB_rob_idx=3; next cycle WB_valid=0.
- Fairness: FU0, FU1 and FU7 valid every cycle with rr_ptr=0 → WB order 0,1,7,0,1,7…; no FU starves.
- Backpressure (BUF_DEPTH=2): FU3 pushes 3 results while FU0 is continuously granted → fu_ready[3]=0 after 2 pushes; the third is held by the FU until a pop.
- Flush in buffers: FU4 holds rob 1 and rob 2; mispredict=1 with flush_mask=8'b0000_0100 → only rob 1 is written back; rob 2 never appears on WB.
- Flush at the input: FU5 pushes rob 6 in the same cycle as mispredict with flush_mask[6]=1 → fu_ready stays 1; no WB beat is produced for rob 6.
- Async reset mid-stream: assert rst between edges while WB_valid=1 and buffers are full → WB_valid drops to 0 immediately, fu_ready becomes all ones, and nothing is emitted after reset is released.
